lfsr_scrambler_multi: RTL

//  Parametrised additive LFSR scrambler/descrambler on AXI-Stream, next generation of the fixed 7-bit scrambler.

---
 rtl/lfsr_scrambler_multi.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/lfsr_scrambler_multi.sv
// Additive LFSR scrambler/descrambler on AXI-Stream with per-frame mode/seed latching,
// seed recovery from known-zero leading bits, tail zeroing and a 2-entry output skid buffer.
module lfsr_scrambler_multi #(
  parameter int unsigned         WIDTH       = 24,
  parameter int unsigned         LFSR_LEN    = 7,
  parameter logic [LFSR_LEN-1:0] POLY        = 7'b1001000,
  parameter logic [LFSR_LEN-1:0] SEED        = 7'b1011101,
  parameter int unsigned         TUSER_WIDTH = 4,
  parameter int unsigned         TAIL_BITS   = 7
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [1:0]             cfg_mode,
  input  logic                   cfg_seed_sel,
  input  logic [LFSR_LEN-1:0]    cfg_seed,
  input  logic [WIDTH-1:0]       s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [WIDTH-1:0]       m_axis_tdata,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [LFSR_LEN-1:0]    rec_seed
);

  typedef enum logic {ST_START, ST_IN_FRAME} state_e;
  typedef enum logic [1:0] {MODE_BYPASS = 2'd0, MODE_SCRAMBLE = 2'd1, MODE_RECOVER = 2'd2} mode_e;

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [LFSR_LEN-1:0]   lfsr_q, lfsr_d;
  logic [LFSR_LEN-1:0]   rec_seed_q, rec_seed_d;

  logic [WIDTH-1:0]       buf_data_q [2];
  logic [WIDTH-1:0]       buf_data_d [2];
  logic [TUSER_WIDTH-1:0] buf_user_q [2];
  logic [TUSER_WIDTH-1:0] buf_user_d [2];
  logic [1:0]             buf_last_q, buf_last_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic                   ready_q, ready_d;

  logic                  accept;
  logic                  drain;
  logic                  at_start;
  logic                  recover_start;
  mode_e                 cfg_mode_dec;
  mode_e                 cur_mode;
  logic [LFSR_LEN-1:0]   seed_sel;
  logic [LFSR_LEN-1:0]   st;
  logic [LFSR_LEN-1:0]   rec_val;
  logic                  fb;
  logic [WIDTH-1:0]      out_data;

  assign accept = s_axis_tvalid & ready_q;
  assign drain  = (count_q != 2'd0) & m_axis_tready;

  // Bit-serial keystream for one beat; bit 0 is oldest in time.
  always_comb begin
    cfg_mode_dec  = (cfg_mode == 2'd3) ? MODE_BYPASS : mode_e'(cfg_mode);
    seed_sel      = cfg_seed_sel ? cfg_seed : SEED;
    at_start      = (state_q == ST_START);
    cur_mode      = at_start ? cfg_mode_dec : mode_q;
    recover_start = at_start && (cur_mode == MODE_RECOVER);
    st            = at_start ? seed_sel : lfsr_q;
    out_data      = s_axis_tdata;
    fb            = 1'b0;
    rec_val       = '0;
    for (int unsigned j = 0; j < LFSR_LEN; j++) begin
      rec_val[LFSR_LEN-1-j] = s_axis_tdata[j];
    end
    if (cur_mode != MODE_BYPASS) begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        // Leading bits of a recovered frame are the keystream itself; shift them in directly.
        if (recover_start && (k < LFSR_LEN)) begin
          out_data[k] = 1'b0;
          st          = {st[LFSR_LEN-2:0], s_axis_tdata[k]};
        end else begin
          fb          = ^(st & POLY);
          out_data[k] = s_axis_tdata[k] ^ fb;
          st          = {st[LFSR_LEN-2:0], fb};
        end
        if ((cur_mode == MODE_SCRAMBLE) && s_axis_tlast && (k + TAIL_BITS >= WIDTH)) begin
          out_data[k] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lfsr_d     = lfsr_q;
    rec_seed_d = rec_seed_q;
    if (accept) begin
      lfsr_d = st;
      if (at_start) begin
        mode_d  = cur_mode;
        state_d = s_axis_tlast ? ST_START : ST_IN_FRAME;
        if (cur_mode == MODE_SCRAMBLE) begin
          rec_seed_d = seed_sel;
        end else if (cur_mode == MODE_RECOVER) begin
          rec_seed_d = rec_val;
        end
      end else if (s_axis_tlast) begin
        state_d = ST_START;
      end
    end
  end

  // Ready is registered from the next occupancy so it only drops when both entries are full.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_user_d = buf_user_q;
    buf_last_d = buf_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (accept) begin
      buf_data_d[wr_ptr_q] = out_data;
      buf_user_d[wr_ptr_q] = s_axis_tuser;
      buf_last_d[wr_ptr_q] = s_axis_tlast;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (drain) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, accept} - {1'b0, drain};
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_START;
      mode_q     <= MODE_BYPASS;
      lfsr_q     <= '0;
      rec_seed_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_user_q[i] <= '0;
      end
      buf_last_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      lfsr_q     <= lfsr_d;
      rec_seed_q <= rec_seed_d;
      buf_data_q <= buf_data_d;
      buf_user_q <= buf_user_d;
      buf_last_q <= buf_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = (count_q != 2'd0);
  assign m_axis_tdata  = buf_data_q[rd_ptr_q];
  assign m_axis_tuser  = buf_user_q[rd_ptr_q];
  assign m_axis_tlast  = buf_last_q[rd_ptr_q];
  assign rec_seed      = rec_seed_q;

endmodule
